instr_encoder: RTL

Pipelined RV32I instruction encoder: takes decoded fields (format class, ALU operation, register indices, immediate) and emits the 32-bit machine word. It is the inverse of the control decoder. It feeds the instruction-memory preload path and the self-checking bench generator, streaming words with a sequential write address.

---
 rtl/instr_encoder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder; 2-cycle latency, 1/cycle, O holds on !out_ready and E stalls behind it.
// Define ENCODER_RANGE_CHECK_EN to flag immediates that do not fit their format as illegal.
package control_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
endpackage

module instr_encoder
    import control_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_fmt,
    input  alu_op_e           in_alu_op,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_illegal
);
    localparam logic [31:0]       NOP       = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [3:0] FMT_R = 4'd0, FMT_I = 4'd1, FMT_LOAD = 4'd2, FMT_STORE = 4'd3,
                           FMT_BRANCH = 4'd4, FMT_JAL = 4'd5, FMT_JALR = 4'd6,
                           FMT_LUI = 4'd7, FMT_AUIPC = 4'd8, FMT_SYSTEM = 4'd9;

    localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [3:0]  fmt;
        alu_op_e     op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    req_t        e_req;
    logic        e_vld;
    logic        e_adv;
    logic        accept;
    logic [31:0] e_imm;
    logic [2:0]  f3_alu;
    logic        is_shift;
    logic        alt_f7;
    logic        bad_fmt;
    logic        bad_rng;
    logic [31:0] enc_raw;
    logic [31:0] enc_instr;
    logic        enc_illegal;

    assign e_adv    = e_vld && (!out_valid || out_ready);
    assign in_ready = !e_vld || e_adv;
    assign accept   = in_valid && in_ready;
    assign e_imm    = e_req.imm;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_vld       <= 1'b0;
            e_req       <= '0;
            out_valid   <= 1'b0;
            out_instr   <= NOP;
            out_illegal <= 1'b0;
            out_addr    <= '0;
        end else if (flush) begin
            e_vld     <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
        end else begin
            if (out_valid && out_ready)
                out_addr <= (out_addr == ADDR_LAST) ? '0 : out_addr + 1'b1;
            if (accept) begin
                e_vld <= 1'b1;
                e_req <= '{fmt: in_fmt, op: in_alu_op, f3: in_funct3, rd: in_rd,
                           rs1: in_rs1, rs2: in_rs2, imm: in_imm};
            end else if (e_adv) begin
                e_vld <= 1'b0;
            end
            if (e_adv) begin
                out_valid   <= 1'b1;
                out_instr   <= enc_instr;
                out_illegal <= enc_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // alt_f7 selects funct7=0100000 (SUB in R form, SRA in both forms)
    always_comb begin
        f3_alu   = 3'b000;
        is_shift = 1'b0;
        alt_f7   = 1'b0;
        case (e_req.op)
            ALU_SUB:  alt_f7 = 1'b1;
            ALU_SLL:  begin f3_alu = 3'b001; is_shift = 1'b1; end
            ALU_SLT:  f3_alu = 3'b010;
            ALU_SLTU: f3_alu = 3'b011;
            ALU_XOR:  f3_alu = 3'b100;
            ALU_SRL:  begin f3_alu = 3'b101; is_shift = 1'b1; end
            ALU_SRA:  begin f3_alu = 3'b101; is_shift = 1'b1; alt_f7 = 1'b1; end
            ALU_OR:   f3_alu = 3'b110;
            ALU_AND:  f3_alu = 3'b111;
            default:  f3_alu = 3'b000;
        endcase
    end

    always_comb begin
        enc_raw = NOP;
        bad_fmt = 1'b0;
        case (e_req.fmt)
            FMT_R:
                enc_raw = {(alt_f7 ? 7'b0100000 : 7'b0), e_req.rs2, e_req.rs1, f3_alu, e_req.rd, OP_R};
            FMT_I:
                if (e_req.op == ALU_SUB)
                    bad_fmt = 1'b1;
                else if (is_shift)
                    enc_raw = {(alt_f7 ? 7'b0100000 : 7'b0), e_imm[4:0], e_req.rs1, f3_alu, e_req.rd, OP_IMM};
                else
                    enc_raw = {e_imm[11:0], e_req.rs1, f3_alu, e_req.rd, OP_IMM};
            FMT_LOAD:
                enc_raw = {e_imm[11:0], e_req.rs1, e_req.f3, e_req.rd, OP_LOAD};
            FMT_STORE:
                enc_raw = {e_imm[11:5], e_req.rs2, e_req.rs1, e_req.f3, e_imm[4:0], OP_STORE};
            FMT_BRANCH:
                enc_raw = {e_imm[12], e_imm[10:5], e_req.rs2, e_req.rs1, e_req.f3,
                           e_imm[4:1], e_imm[11], OP_BRANCH};
            FMT_JAL:
                enc_raw = {e_imm[20], e_imm[10:1], e_imm[11], e_imm[19:12], e_req.rd, OP_JAL};
            FMT_JALR:
                enc_raw = {e_imm[11:0], e_req.rs1, 3'b000, e_req.rd, OP_JALR};
            FMT_LUI:
                enc_raw = {e_imm[31:12], e_req.rd, OP_LUI};
            FMT_AUIPC:
                enc_raw = {e_imm[31:12], e_req.rd, OP_AUIPC};
            FMT_SYSTEM:
                enc_raw = e_imm[0] ? 32'h0010_0073 : 32'h0000_0073;
            default:
                bad_fmt = 1'b1;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    logic fits_i;
    logic fits_b;
    logic fits_j;

    // A value fits N signed bits when everything above bit N-1 copies the sign bit.
    assign fits_i = (e_imm[31:11] == '0) || (e_imm[31:11] == '1);
    assign fits_b = ((e_imm[31:12] == '0) || (e_imm[31:12] == '1)) && !e_imm[0];
    assign fits_j = ((e_imm[31:20] == '0) || (e_imm[31:20] == '1)) && !e_imm[0];

    always_comb begin
        bad_rng = 1'b0;
        case (e_req.fmt)
            FMT_I:                       bad_rng = is_shift ? (e_imm[31:5] != '0) : !fits_i;
            FMT_LOAD, FMT_STORE, FMT_JALR: bad_rng = !fits_i;
            FMT_BRANCH:                  bad_rng = !fits_b;
            FMT_JAL:                     bad_rng = !fits_j;
            FMT_LUI, FMT_AUIPC:          bad_rng = (e_imm[11:0] != '0);
            default:                     bad_rng = 1'b0;
        endcase
    end
`else
    assign bad_rng = 1'b0;
`endif

    assign enc_illegal = bad_fmt || bad_rng;
    assign enc_instr   = enc_illegal ? NOP : enc_raw;
endmodule
